// File: rtl/fifo_rd_resp_pusher.sv
// Read-response pusher: fetches a word from memory or the register bank
// and pushes {address, data} into the outbound FIFO pair.
module fifo_rd_resp_pusher #(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        req_valid_i,
    input  logic [31:0] req_addr_i,
    output logic        req_ready_o,
    output logic        mem_rd_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        reg_rd_o,
    output logic [31:0] reg_addr_o,
    input  logic [31:0] reg_rdata_i,
    input  logic        wr_full_addr,
    input  logic        wr_full_data,
    output logic        write_en_address,
    output logic        write_en_data,
    output logic [31:0] address_fifo_o,
    output logic [31:0] data_fifo_o,
    output logic        timeout_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] PUSH  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic is_reg;
    logic push_ok;
    logic tmo;

    assign is_reg  = addr_q[10];
    assign push_ok = !wr_full_addr && !wr_full_data;
    // Data arriving on the last allowed cycle beats the timeout.
    assign tmo     = (state_q == WAIT) && !is_reg && !mem_rvalid_i
                   && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        data_d           = data_q;
        cnt_d            = cnt_q;
        req_ready_o      = 1'b0;
        mem_rd_o         = 1'b0;
        mem_addr_o       = '0;
        reg_rd_o         = 1'b0;
        reg_addr_o       = '0;
        write_en_address = 1'b0;
        write_en_data    = 1'b0;
        address_fifo_o   = '0;
        data_fifo_o      = '0;
        timeout_o        = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    addr_d = req_addr_i;
                    if (!req_addr_i[17]) begin
                        data_d  = ERR_DATA;
                        state_d = PUSH;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (is_reg) begin
                    reg_rd_o   = 1'b1;
                    reg_addr_o = addr_q;
                end else begin
                    mem_rd_o   = 1'b1;
                    mem_addr_o = addr_q;
                end
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (is_reg) begin
                    data_d  = reg_rdata_i;
                    state_d = PUSH;
                end else begin
                    mem_addr_o = addr_q;
                    if (mem_rvalid_i) begin
                        data_d  = mem_rdata_i;
                        state_d = PUSH;
                    end else if (tmo) begin
                        data_d    = ERR_DATA;
                        timeout_o = 1'b1;
                        state_d   = PUSH;
                    end else if (cnt_q != CW'(TIMEOUT)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            PUSH: begin
                address_fifo_o = addr_q;
                data_fifo_o    = data_q;
                if (push_ok) begin
                    write_en_address = 1'b1;
                    write_en_data    = 1'b1;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
